// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel window scan controller.
package sobel_pkg;

    typedef enum logic {
        StIdle,
        StRun
    } state_t;

    localparam int unsigned DEF_IMG_W = 64;
    localparam int unsigned DEF_IMG_H = 64;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int unsigned width_of(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-N up counter with synchronous clear; wrap flags the increment that rolls over.
module wrap_counter
    import sobel_pkg::*;
#(
    parameter int unsigned MODULUS = 4,
    parameter int unsigned W       = width_of(MODULUS)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap
);

    assign wrap = inc && (count == W'(MODULUS - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc) begin
            count <= wrap ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/sobel_scan_ctrl.sv
// Raster-scan controller issuing one 3x3 window centre per accepted tick over a frame.
module sobel_scan_ctrl
    import sobel_pkg::*;
#(
    parameter int unsigned IMG_W  = DEF_IMG_W,
    parameter int unsigned IMG_H  = DEF_IMG_H,
    parameter int unsigned ADDR_W = width_of(IMG_W * IMG_H)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        tick,
    input  logic                        start,
    input  logic                        pause,
    output logic [width_of(IMG_H)-1:0]  row,
    output logic [width_of(IMG_W)-1:0]  col,
    output logic [ADDR_W-1:0]           addr,
    output logic                        border,
    output logic                        win_valid,
    output logic                        busy,
    output logic                        done
);

    localparam int unsigned ROW_W = width_of(IMG_H);
    localparam int unsigned COL_W = width_of(IMG_W);

    state_t state_q, state_d;

    logic             issue;
    logic             clear_pos;
    logic             col_wrap;
    logic             row_wrap;
    logic [COL_W-1:0] col_cnt;
    logic [ROW_W-1:0] row_cnt;
    logic [ADDR_W-1:0] addr_cnt;
    logic             edge_pos;

    assign issue = (state_q == StRun) && tick && !pause;
    assign busy  = (state_q == StRun);

    wrap_counter #(
        .MODULUS (IMG_W),
        .W       (COL_W)
    ) u_col_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (clear_pos),
        .inc   (issue),
        .count (col_cnt),
        .wrap  (col_wrap)
    );

    // Row wrap only fires on the final position of the frame.
    wrap_counter #(
        .MODULUS (IMG_H),
        .W       (ROW_W)
    ) u_row_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (clear_pos),
        .inc   (col_wrap),
        .count (row_cnt),
        .wrap  (row_wrap)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clear_pos = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    clear_pos = 1'b1;
                    state_d   = StRun;
                end
            end
            StRun: begin
                if (row_wrap) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Linear address tracks the raster position, avoiding a row*IMG_W multiply.
    always_ff @(posedge clk) begin
        if (reset || clear_pos) begin
            addr_cnt <= '0;
        end else if (issue) begin
            addr_cnt <= row_wrap ? '0 : addr_cnt + ADDR_W'(1);
        end
    end

    assign edge_pos = (row_cnt == '0) || (row_cnt == ROW_W'(IMG_H - 1)) ||
                      (col_cnt == '0) || (col_cnt == COL_W'(IMG_W - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            row       <= '0;
            col       <= '0;
            addr      <= '0;
            border    <= 1'b0;
            win_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            win_valid <= issue;
            done      <= row_wrap;
            if (issue) begin
                row    <= row_cnt;
                col    <= col_cnt;
                addr   <= addr_cnt;
                border <= edge_pos;
            end
        end
    end

endmodule

// File: tb/tb_sobel_scan_ctrl.sv
// Self-checking bench for sobel_scan_ctrl on a 4x3 image.
module tb_sobel_scan_ctrl;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       start;
    logic       pause;
    logic [1:0] row;
    logic [1:0] col;
    logic [3:0] addr;
    logic       border;
    logic       win_valid;
    logic       busy;
    logic       done;

    sobel_scan_ctrl #(
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .start     (start),
        .pause     (pause),
        .row       (row),
        .col       (col),
        .addr      (addr),
        .border    (border),
        .win_valid (win_valid),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: position is a single linear index k into the frame.
    logic       m_run;
    int         m_k;
    logic [1:0] m_row, m_col;
    logic [3:0] m_addr;
    logic       m_border, m_wv, m_done;

    always @(posedge clk) begin
        if (reset) begin
            m_run <= 1'b0; m_k <= 0;
            m_row <= '0; m_col <= '0; m_addr <= '0;
            m_border <= 1'b0; m_wv <= 1'b0; m_done <= 1'b0;
        end else begin
            m_wv   <= 1'b0;
            m_done <= 1'b0;
            if (!m_run) begin
                if (start) begin
                    m_run <= 1'b1;
                    m_k   <= 0;
                end
            end else if (tick && !pause) begin
                m_wv     <= 1'b1;
                m_row    <= 2'(m_k / W);
                m_col    <= 2'(m_k % W);
                m_addr   <= 4'(m_k);
                m_border <= (m_k / W == 0) || (m_k / W == H - 1) ||
                            (m_k % W == 0) || (m_k % W == W - 1);
                if (m_k == N - 1) begin
                    m_done <= 1'b1;
                    m_run  <= 1'b0;
                end
                m_k <= m_k + 1;
            end
        end
    end

    logic check_en = 1'b0;
    initial begin
        @(posedge clk);
        check_en = 1'b1;
    end

    int         wv_count   = 0;
    int         done_count = 0;
    int         done_idx   = -1;
    logic [3:0] cap_addr   [32];
    int         cap_row    [32];
    int         cap_col    [32];
    logic       cap_border [32];

    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                check("win_valid", win_valid, m_wv);
                check("done", done, m_done);
                check("busy", busy, m_run);
                check("row", row, m_row);
                check("col", col, m_col);
                check("addr", addr, m_addr);
                check("border", border, m_border);
                if (win_valid === 1'b1 && wv_count < 32) begin
                    cap_addr[wv_count]   = addr;
                    cap_row[wv_count]    = int'(row);
                    cap_col[wv_count]    = int'(col);
                    cap_border[wv_count] = border;
                end
                if (win_valid === 1'b1) wv_count++;
                if (done === 1'b1) begin
                    done_count++;
                    done_idx = wv_count - 1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_tick(input int gap);
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    logic [11:0] bmask;

    initial begin
        reset = 1'b1; tick = 1'b0; start = 1'b0; pause = 1'b0;
        bmask = 12'b1111_1001_1111;
        cyc(3);
        #1;
        check("rst_row", row, 0);
        check("rst_col", col, 0);
        check("rst_addr", addr, 0);
        check("rst_border", border, 0);
        check("rst_wv", win_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk); reset = 1'b0;

        // Ticks while idle are ignored.
        repeat (3) pulse_tick(2);
        #1;
        check("idle_ticks_wv", wv_count, 0);
        check("idle_busy", busy, 0);

        // Start with a coincident tick: no window from that tick.
        @(negedge clk); start = 1'b1; tick = 1'b1;
        @(negedge clk); start = 1'b0; tick = 1'b0;
        cyc(3);
        #1;
        check("start_tick_wv", wv_count, 0);
        check("run_busy", busy, 1);

        // Full frame, with a stray start mid-frame.
        for (int i = 0; i < N; i++) begin
            pulse_tick(3);
            if (i == 3) do_start();
        end
        cyc(2);
        #1;
        check("frame_wv_count", wv_count, N);
        check("frame_done_count", done_count, 1);
        check("frame_done_idx", done_idx, N - 1);
        check("frame_busy_after", busy, 0);
        for (int k = 0; k < N; k++) begin
            check("frame_addr", cap_addr[k], k);
            check("frame_row", cap_row[k], k / 4);
            check("frame_col", cap_col[k], k % 4);
            check("frame_border", cap_border[k], bmask[k]);
        end

        pulse_tick(2);
        #1;
        check("post_frame_idle_wv", wv_count, 12);

        // Pause drops ticks and holds the position.
        do_start();
        pulse_tick(3);
        pulse_tick(3);
        @(negedge clk); pause = 1'b1;
        repeat (3) pulse_tick(2);
        #1;
        check("pause_wv_count", wv_count, 14);
        check("pause_addr_held", addr, 1);
        @(negedge clk); pause = 1'b0;
        pulse_tick(3);
        #1;
        check("resume_addr", cap_addr[14], 2);
        check("resume_row", cap_row[14], 0);
        check("resume_col", cap_col[14], 2);

        // Abort after five issues, then restart.
        pulse_tick(3);
        pulse_tick(3);
        #1;
        check("abort_pre_wv", wv_count, 17);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        #1;
        check("abort_row", row, 0);
        check("abort_col", col, 0);
        check("abort_addr", addr, 0);
        check("abort_border", border, 0);
        check("abort_wv", win_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_done_count", done_count, 1);
        do_start();
        pulse_tick(3);
        #1;
        check("restart_wv_count", wv_count, 18);
        check("restart_addr", cap_addr[17], 0);
        check("restart_row", cap_row[17], 0);
        check("restart_col", cap_col[17], 0);

        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sobel_scan_ctrl.md
SOBEL_SCAN_CTRL -- requirements
Module: sobel_scan_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 64, image width in pixels (>=3).
REQ-002 SHALL have parameter IMG_H, default 64, image height in pixels (>=3).
REQ-003 SHALL have parameter ADDR_W, default clog2(IMG_W*IMG_H), linear pixel-address width.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous, active-high reset (reset reset, synchronous, active-high; clock clk).
REQ-006 tick  input  1  single-cycle step pulse from the upstream pulse generator.
REQ-007 start  input  1  begin a frame scan; sampled in IDLE only.
REQ-008 pause  input  1  level; while high, ticks are dropped.
REQ-009 row  output  clog2(IMG_H)  window-centre row of the current issue.
REQ-010 col  output  clog2(IMG_W)  window-centre column of the current issue.
REQ-011 addr  output  ADDR_W  linear address, row*IMG_W+col.
REQ-012 border  output  1  high when the window centre lies on an image edge.
REQ-013 win_valid  output  1  single-cycle qualifier for row/col/addr/border.
REQ-014 busy  output  1  high while a scan is in progress.
REQ-015 done  output  1  single-cycle end-of-frame pulse.

Function
REQ-016 SHALL implement states IDLE and RUN.
REQ-017 IDLE: busy=0; start=1 SHALL load the internal position (0,0) and enter RUN next cycle; ticks SHALL be ignored.
REQ-018 A tick in the same cycle as start in IDLE SHALL be ignored; the first window requires a later tick.
REQ-019 RUN: busy=1; tick=1 with pause=0 SHALL, on the next cycle, present win_valid=1 with row, col, addr and border of the current position (latency 1 cycle, all outputs registered together).
REQ-020 After each issue, col SHALL increment; at col=IMG_W-1, col SHALL wrap to 0 and row SHALL increment.
REQ-021 Issuing position (IMG_H-1, IMG_W-1) SHALL assert done in the same cycle as that win_valid, and the block SHALL return to IDLE (busy=0 in that cycle).
REQ-022 tick with pause=1 SHALL be dropped, not queued; the position SHALL stay unchanged.
REQ-023 start while in RUN SHALL be ignored.
REQ-024 win_valid and done SHALL be low in every cycle not defined above; row/col/addr/border SHALL hold their last issued values between issues.
REQ-025 border SHALL equal (row==0)|(row==IMG_H-1)|(col==0)|(col==IMG_W-1) for the issued position.
REQ-026 addr SHALL be computed without overflow at ADDR_W bits; the multiply SHALL be replaced by an incrementing address counter that resets to 0 with the position.

Reset
REQ-027 reset SHALL force state IDLE, internal position (0,0), and row=col=addr=0, border=0, win_valid=0, busy=0, done=0.
REQ-028 reset SHALL take priority over start and tick in the same cycle.
REQ-029 reset mid-frame SHALL abort the scan without a done pulse; a subsequent start SHALL restart at (0,0).

Structure
REQ-030 Shared package sobel_pkg SHALL hold the state enumeration, the default IMG_W/IMG_H constants and the width-derivation helper.
REQ-031 The column and row counters SHALL each be an instance of the sub-module wrap_counter (parameterised modulus, inc input, wrap output, synchronous clear).

Verification (IMG_W=4, IMG_H=3)
REQ-032 Full frame: reset, start, then 12 ticks 5 cycles apart -> 12 win_valid pulses, each 1 cycle after its tick, at (0,0),(0,1)..(2,3), addr 0..11; done=1 with the 12th only; busy=0 thereafter.
REQ-033 Border: same frame -> border=0 only at (1,1)/addr 5 and (1,2)/addr 6; border=1 at all other 10 positions.
REQ-034 Pause: after 2 issues, pause=1 across 3 ticks -> no win_valid and position held; first tick after pause=0 -> (0,2), addr 2.
REQ-035 Ignored inputs: ticks in IDLE -> no win_valid; start+tick in the same cycle -> no win_valid until the next tick; start during RUN -> no restart.
REQ-036 Abort: reset after 5 issues -> all outputs 0 on the next cycle, no done; start then tick -> (0,0), addr 0.
